ifu_fetch_bus: RTL and testbench

Fetch stage that feeds the IF/ID pipeline register. It owns the PC and issues single-beat instruction reads on an AXI-lite-style AR/R read port. It presents inst/pc/snpc with a valid/ready handshake toward decode, and squashes in-flight or held fetches on a redirect from a later stage. One outstanding request at a time.

---
 rtl/ifu_fetch_bus_pkg.sv | 19 +
 rtl/ifu_fetch_bus_if.sv | 24 ++
 rtl/ifu_fetch_bus.sv | 136 +++++++++++++
 tb/tb_ifu_fetch_bus.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_bus_pkg.sv
// Shared definitions for the instruction fetch stage and the IF/ID register.
package ifu_fetch_bus_pkg;

  // Fetch FSM: issue address, wait for the data beat, hold the result for decode.
  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT_R = 2'd1,
    ST_HOLD   = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Fetch PCs are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_bus_if.sv
// AXI-lite-style single-beat read port (AR and R channels only).
interface ifu_fetch_bus_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  // Fetch side issues reads.
  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  // Memory side answers reads.
  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ifu_fetch_bus.sv
// Fetch stage: owns the PC, issues one outstanding read at a time and hands
// inst/pc/snpc to decode over a valid/ready handshake. A redirect squashes
// whatever is in flight; the one response already requested is discarded.
module ifu_fetch_bus
  import ifu_fetch_bus_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  ifu_fetch_bus_if.master   bus,
  output logic [INST_W-1:0] instF,
  output logic [31:0]       pcF,
  output logic [31:0]       snpcF,
  output logic              errF,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       araddr_q, araddr_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       pcf_q, pcf_d;
  logic [31:0]       snpcf_q, snpcf_d;
  logic              errf_q, errf_d;

  logic [31:0]       redir_pc;

  assign redir_pc = align_pc(redirect_pc);

  // Handshake outputs decode straight from the state.
  assign bus.arvalid = (state_q == ST_REQ);
  assign bus.rready  = (state_q == ST_WAIT_R);
  assign bus.araddr  = araddr_q;
  assign m_valid     = (state_q == ST_HOLD);
  assign instF       = inst_q;
  assign pcF         = pcf_q;
  assign snpcF       = snpcf_q;
  assign errF        = errf_q;

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      araddr_q <= RESET_PC;
      drop_q   <= 1'b0;
      inst_q   <= '0;
      pcf_q    <= RESET_PC;
      snpcf_q  <= RESET_PC + 32'd4;
      errf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      araddr_q <= araddr_d;
      drop_q   <= drop_d;
      inst_q   <= inst_d;
      pcf_q    <= pcf_d;
      snpcf_q  <= snpcf_d;
      errf_q   <= errf_d;
    end
  end

  // Next-state logic: FSM transitions, pc/araddr steering and squash tracking.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    araddr_d = araddr_q;
    drop_d   = drop_q;
    inst_d   = inst_q;
    pcf_d    = pcf_q;
    snpcf_d  = snpcf_q;
    errf_d   = errf_q;

    unique case (state_q)
      ST_REQ: begin
        // araddr must not move while arvalid is up, so a redirect here only
        // retargets pc and marks the pending response for discard.
        if (bus.arready) begin
          state_d = ST_WAIT_R;
        end
        if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end

      ST_WAIT_R: begin
        if (bus.rvalid) begin
          if (drop_q || redirect_valid) begin
            // Squashed beat: exactly one response is thrown away.
            drop_d   = 1'b0;
            state_d  = ST_REQ;
            araddr_d = redirect_valid ? redir_pc : pc_q;
            if (redirect_valid) begin
              pc_d = redir_pc;
            end
          end else begin
            inst_d  = bus.rdata;
            pcf_d   = araddr_q;
            snpcf_d = araddr_q + 32'd4;
            errf_d  = (bus.rresp != RESP_OKAY);
            state_d = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end

      ST_HOLD: begin
        // A redirect wins over the sequential advance even if decode takes
        // the current instruction in the same cycle.
        if (redirect_valid) begin
          pc_d     = redir_pc;
          araddr_d = redir_pc;
          state_d  = ST_REQ;
        end else if (m_ready) begin
          pc_d     = pcf_q + 32'd4;
          araddr_d = pcf_q + 32'd4;
          state_d  = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch_bus.sv
// Directed bench for the fetch stage: memory and decode are driven by hand.
module tb_ifu_fetch_bus;
  import ifu_fetch_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instF, pcF, snpcF;
  logic        errF, m_valid, m_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  ifu_fetch_bus_if #(.DATA_W(32)) bus ();

  ifu_fetch_bus #(
    .RESET_PC (32'h8000_0000),
    .INST_W   (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.master),
    .instF          (instF),
    .pcF            (pcF),
    .snpcF          (snpcF),
    .errF           (errF),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %0d %s observed=%h expected=%h", checks, tag, obs, exp);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    bus.rresp = RESP_OKAY;
    m_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    tick();

    // Reset state.
    chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_rready", {31'd0, bus.rready}, 32'd0);
    chk("rst_instF", instF, 32'h0);
    chk("rst_pcF", pcF, 32'h8000_0000);
    chk("rst_snpcF", snpcF, 32'h8000_0004);
    chk("rst_errF", {31'd0, errF}, 32'd0);

    // 1. First fetch with a zero-wait memory.
    rst = 1'b0;
    bus.arready = 1'b1;
    chk("t1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    chk("t1_araddr", bus.araddr, 32'h8000_0000);
    tick();
    chk("t1_rready", {31'd0, bus.rready}, 32'd1);
    chk("t1_arvalid_low", {31'd0, bus.arvalid}, 32'd0);
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_0013;
    tick();
    bus.rvalid = 1'b0;
    chk("t1_mvalid", {31'd0, m_valid}, 32'd1);
    chk("t1_instF", instF, 32'h0000_0013);
    chk("t1_pcF", pcF, 32'h8000_0000);
    chk("t1_snpcF", snpcF, 32'h8000_0004);

    // 2. Decode stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_mvalid", {31'd0, m_valid}, 32'd1);
      chk("t2_instF", instF, 32'h0000_0013);
      chk("t2_pcF", pcF, 32'h8000_0000);
      chk("t2_snpcF", snpcF, 32'h8000_0004);
      chk("t2_arvalid", {31'd0, bus.arvalid}, 32'd0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t2_next_araddr", bus.araddr, 32'h8000_0004);
    chk("t2_mvalid_low", {31'd0, m_valid}, 32'd0);

    // 3. arready late, redirect while the address is still pending.
    bus.arready = 1'b0;
    chk("t3_araddr_c1", bus.araddr, 32'h8000_0004);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    chk("t3_araddr_c2", bus.araddr, 32'h8000_0004);
    tick();
    redirect_valid = 1'b0;
    chk("t3_araddr_c3", bus.araddr, 32'h8000_0004);
    chk("t3_arvalid_c3", {31'd0, bus.arvalid}, 32'd1);
    tick();
    bus.arready = 1'b1;
    chk("t3_araddr_hs", bus.araddr, 32'h8000_0004);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hAAAA_AAAA;
    tick();
    bus.rvalid = 1'b0;
    chk("t3_dropped_mvalid", {31'd0, m_valid}, 32'd0);
    chk("t3_redir_araddr", bus.araddr, 32'h8000_0100);
    chk("t3_redir_arvalid", {31'd0, bus.arvalid}, 32'd1);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h1111_1111;
    tick();
    bus.rvalid = 1'b0;
    chk("t3_mvalid", {31'd0, m_valid}, 32'd1);
    chk("t3_instF", instF, 32'h1111_1111);
    chk("t3_pcF", pcF, 32'h8000_0100);
    chk("t3_snpcF", snpcF, 32'h8000_0104);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t3_next_araddr", bus.araddr, 32'h8000_0104);

    // 4. Redirect coincides with rvalid; low bits of redirect_pc are ignored.
    tick();
    chk("t4_rready", {31'd0, bus.rready}, 32'd1);
    bus.rvalid = 1'b1; bus.rdata = 32'hBBBB_BBBB;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
    tick();
    bus.rvalid = 1'b0; redirect_valid = 1'b0;
    chk("t4_mvalid", {31'd0, m_valid}, 32'd0);
    chk("t4_arvalid", {31'd0, bus.arvalid}, 32'd1);
    chk("t4_araddr", bus.araddr, 32'h8000_0200);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h2222_2222;
    tick();
    bus.rvalid = 1'b0;
    chk("t4_next_mvalid", {31'd0, m_valid}, 32'd1);
    chk("t4_next_pcF", pcF, 32'h8000_0200);
    chk("t4_next_instF", instF, 32'h2222_2222);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t4_seq_araddr", bus.araddr, 32'h8000_0204);

    // 5. Error response, then a normal one.
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b10;
    tick();
    bus.rvalid = 1'b0; bus.rresp = RESP_OKAY;
    chk("t5_errF", {31'd0, errF}, 32'd1);
    chk("t5_instF", instF, 32'hDEAD_BEEF);
    chk("t5_pcF", pcF, 32'h8000_0204);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t5_next_araddr", bus.araddr, 32'h8000_0208);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h3333_3333;
    tick();
    bus.rvalid = 1'b0;
    chk("t5_ok_errF", {31'd0, errF}, 32'd0);
    chk("t5_ok_pcF", pcF, 32'h8000_0208);

    // 6. Redirect from HOLD to the top of the address space, wrap on +4.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t6_mvalid_low", {31'd0, m_valid}, 32'd0);
    chk("t6_araddr", bus.araddr, 32'hFFFF_FFFC);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'h4444_4444;
    tick();
    bus.rvalid = 1'b0;
    chk("t6_pcF", pcF, 32'hFFFF_FFFC);
    chk("t6_snpcF", snpcF, 32'h0000_0000);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t6_wrap_araddr", bus.araddr, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
